systolic_input_skewer: RTL and testbench
========================================

// Module: systolic_input_skewer
// PURPOSE
//  Upstream feeder of the PE_VCounter systolic array. It accepts one k-slice per beat from the
//  operand source: column k of A and row k of B, DIMENSION elements each.
//  It applies the diagonal skew: lane i is delayed i cycles relative to lane 0.
//  It issues the per-lane reset pulse that clears the edge PEs before each matrix, then drains
//  with zeros so that every PE sees exactly DIMENSION products.
// PARAMETERS
//  DIMENSION  4  array side, number of lanes; >=2
//  I_BITS     8  operand width, signed S(I_BITS,I_BITS-1)
// PORTS
//  i_clock      in   1              single clock, rising edge
//  i_reset      in   1              synchronous, active-high
//  i_start      in   1              begin one matrix; sampled only in IDLE
//  i_valid      in   1              source beat valid
//  o_ready      out  1              block accepts beat (LOAD state only)
//  i_a_col      in   DIMENSION*I_BITS  A[lane][k]; lane i = bits [i*I_BITS +: I_BITS]
//  i_b_row      in   DIMENSION*I_BITS  B[k][lane], same packing
//  o_a          out  DIMENSION*I_BITS  skewed A, to row-edge PEs i_a
//  o_b          out  DIMENSION*I_BITS  skewed B, to column-edge PEs i_b
//  o_a_reset    out  DIMENSION      skewed reset, to row-edge PEs i_a_reset
//  o_b_reset    out  DIMENSION      skewed reset, to column-edge PEs i_b_reset
//  o_busy       out  1              high in any state except IDLE
//  o_done       out  1              1-cycle pulse: last skewed element has left lane DIMENSION-1
//  o_underrun   out  1              sticky: i_valid was low during a LOAD cycle
// BEHAVIOUR
//  Reset values: all outputs 0. FSM state is IDLE. Delay lines are cleared to 0.
//  FSM: IDLE -> PRIME -> LOAD -> DRAIN -> IDLE.
//   IDLE:  o_ready=0; lane-0 input is 0. i_start=1 -> PRIME.
//   PRIME: 1 cycle; the lane-0 reset input is 1 and the data input is 0 -> LOAD.
//   LOAD:  exactly DIMENSION cycles, counted by beat counter k, 0..DIMENSION-1.
//          o_ready=1. The beat is consumed every cycle regardless of i_valid.
//          If i_valid=0, zeros are injected and o_underrun is set.
//          The PE counters are free-running, so a LOAD cycle is never stalled.
//          k==DIMENSION-1 -> DRAIN.
//   DRAIN: DIMENSION cycles, zeros in. At the end, o_done=1 for 1 cycle -> IDLE.
//  Skew and latency:
//   - Lane i data and reset go through i+1 register stages.
//   - o_a_reset[i] is high in cycle tP+1+i, where tP is the PRIME cycle.
//   - Element k of lane i appears on o_a/o_b in cycle tP+2+i+k.
//   - The reset always precedes data by exactly one cycle on the same lane.
//   - o_a_reset and o_b_reset are identical.
//  Timing: o_done is asserted in cycle tP+1+2*DIMENSION. The total occupancy is 2*DIMENSION+1 cycles.
//  Arithmetic: none. Data is passed bit-exact and signed.
//  i_start outside IDLE is ignored and is not queued.
//  Boundary conditions:
//   - i_start in the same cycle as o_done: ignored, because the FSM is leaving DRAIN.
//     It is accepted in the next IDLE cycle.
//   - i_reset mid-operation: next cycle is IDLE, delay lines are zeroed, and no o_done is emitted.
//     o_underrun is cleared only by i_reset.
//   - o_underrun is sampled per LOAD cycle. It is unaffected by i_valid in other states.
// STRUCTURE
//  Shared include systolic_defs.vh: DIMENSION/I_BITS defaults, the FSM state encodings
//  (IDLE, PRIME, LOAD, DRAIN), and the lane pack/unpack index macro.
//  Sub-module skew_delay_line #(DEPTH, WIDTH): a shift register with synchronous clear.
//  It is instantiated per lane with DEPTH=i+1 and WIDTH=2*I_BITS+1 (a, b, reset bit).
//  Top level: FSM, beat counter k (clog2(DIMENSION+1) bits), drain counter, lane generate loop.
// TESTING  (DIMENSION=4, I_BITS=8)
//  1. Reset held 3 cycles, then released -> all outputs 0, o_busy=0, o_ready=0.
//  2. i_start, then 4 valid beats, lane i of beat k = 16*i+k
//     -> o_a_reset = 0001,0010,0100,1000 in cycles tP+1..tP+4.
//     -> o_a[lane2]=0x20 at tP+4, 0x23 at tP+7. o_done at tP+9.
//  3. Array loopback with PE_VCounter x16: A=identity, B=[1..16] row-major
//     -> every PE asserts o_finish. Result C equals B (Q-format at rf_matrix_size 0).
//  4. Negative operands: A lanes all 0x80 (-1.0), B lanes 0x40 (+0.5)
//     -> data is passed bit-exact, sign preserved, on all lanes.
//  5. i_valid=0 during beat k=2 -> zeros are injected at k=2, o_underrun=1 and sticky.
//     Timing is unchanged: o_done still at tP+9.
//  6. i_reset asserted at tP+5 -> IDLE in the next cycle. Outputs are 0, no o_done pulse.
//     A following i_start is handled normally.

Source files
------------

// File: rtl/systolic_input_skewer_pkg.sv
// Shared defaults, FSM state encodings and lane packing helper for the systolic input skewer.
package systolic_input_skewer_pkg;

  localparam int DIMENSION_DEF = 4;
  localparam int I_BITS_DEF    = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Low bit of a lane inside a packed lane vector.
  function automatic int lane_lsb(input int lane, input int bits);
    return lane * bits;
  endfunction

endpackage

// File: rtl/systolic_input_skewer_delay_line.sv
// skew_delay_line: DEPTH-stage shift register with synchronous clear; output is the last stage.
module skew_delay_line
  import systolic_input_skewer_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      for (int s = 0; s < DEPTH; s++) stage_reg[s] <= '0;
    end else begin
      stage_reg[0] <= i_data;
      for (int s = 1; s < DEPTH; s++) stage_reg[s] <= stage_reg[s-1];
    end
  end

  assign o_data = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_input_skewer.sv
// Feeds a systolic array: primes edge PEs with a reset pulse, loads DIMENSION k-slices,
// then drains zeros, with lane i delayed by i cycles relative to lane 0.
module systolic_input_skewer
  import systolic_input_skewer_pkg::*;
#(
  parameter int DIMENSION = DIMENSION_DEF,
  parameter int I_BITS    = I_BITS_DEF
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [DIMENSION*I_BITS-1:0] i_a_col,
  input  logic [DIMENSION*I_BITS-1:0] i_b_row,
  output logic [DIMENSION*I_BITS-1:0] o_a,
  output logic [DIMENSION*I_BITS-1:0] o_b,
  output logic [DIMENSION-1:0]        o_a_reset,
  output logic [DIMENSION-1:0]        o_b_reset,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_underrun
);

  localparam int CNT_W = $clog2(DIMENSION + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIMENSION - 1);
  localparam int LANE_W = 2 * I_BITS + 1;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] beat_reg;
  logic [CNT_W-1:0] drain_reg;
  logic             done_reg;
  logic             underrun_reg;
  logic             prime_pulse;
  logic             load_beat;

  // A start arriving while o_done is high belongs to the DRAIN exit and is dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (i_start && !done_reg) state_next = ST_PRIME;
      ST_PRIME: state_next = ST_LOAD;
      ST_LOAD:  if (beat_reg == LAST_CNT) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_reg == LAST_CNT) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg    <= ST_IDLE;
      beat_reg     <= '0;
      drain_reg    <= '0;
      done_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= (state_reg == ST_LOAD) ? beat_reg + 1'b1 : '0;
      drain_reg <= (state_reg == ST_DRAIN) ? drain_reg + 1'b1 : '0;
      done_reg  <= (state_reg == ST_DRAIN) && (drain_reg == LAST_CNT);
      if ((state_reg == ST_LOAD) && !i_valid) underrun_reg <= 1'b1;
    end
  end

  assign prime_pulse = (state_reg == ST_PRIME);
  assign load_beat   = (state_reg == ST_LOAD) && i_valid;

  assign o_ready    = (state_reg == ST_LOAD);
  assign o_busy     = (state_reg != ST_IDLE);
  assign o_done     = done_reg;
  assign o_underrun = underrun_reg;

  generate
    for (genvar gi = 0; gi < DIMENSION; gi++) begin : g_lane
      localparam int LSB = lane_lsb(gi, I_BITS);
      logic [LANE_W-1:0] lane_in;
      logic [LANE_W-1:0] lane_out;

      // Missing beats are replaced by zeros so PE counters stay aligned.
      assign lane_in = {prime_pulse,
                        load_beat ? i_a_col[LSB +: I_BITS] : {I_BITS{1'b0}},
                        load_beat ? i_b_row[LSB +: I_BITS] : {I_BITS{1'b0}}};

      skew_delay_line #(
        .DEPTH(gi + 1),
        .WIDTH(LANE_W)
      ) u_delay (
        .i_clock(i_clock),
        .i_clear(i_reset),
        .i_data (lane_in),
        .o_data (lane_out)
      );

      assign o_a_reset[gi]         = lane_out[LANE_W-1];
      assign o_b_reset[gi]         = lane_out[LANE_W-1];
      assign o_a[LSB +: I_BITS]    = lane_out[2*I_BITS-1:I_BITS];
      assign o_b[LSB +: I_BITS]    = lane_out[I_BITS-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Scoreboard bench: the driver pushes per-cycle expectations from a timing-rule model; a monitor compares.
module tb_systolic_input_skewer;

  localparam int D = 4;
  localparam int W = 8;

  logic           i_clock = 1'b0;
  logic           i_reset, i_start, i_valid;
  logic [D*W-1:0] i_a_col, i_b_row, o_a, o_b;
  logic [D-1:0]   o_a_reset, o_b_reset;
  logic           o_ready, o_busy, o_done, o_underrun;

  systolic_input_skewer #(.DIMENSION(D), .I_BITS(W)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_valid(i_valid),
    .o_ready(o_ready), .i_a_col(i_a_col), .i_b_row(i_b_row), .o_a(o_a), .o_b(o_b),
    .o_a_reset(o_a_reset), .o_b_reset(o_b_reset), .o_busy(o_busy), .o_done(o_done),
    .o_underrun(o_underrun)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [D*W-1:0] a;
    logic [D*W-1:0] b;
    logic [D-1:0]   ar;
    logic [D-1:0]   br;
    logic           busy;
    logic           ready;
    logic           done;
    logic           und;
  } obs_t;

  obs_t exp_q[$];
  int   stamp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model of the current matrix: beat k, lane i.
  logic [W-1:0] ma [D][D];
  logic [W-1:0] mb [D][D];
  bit           minv [D];
  bit           sticky = 1'b0;

  always @(posedge i_clock) cyc <= cyc + 1;

  // Expected outputs r cycles after the PRIME cycle, from the skew/latency rules.
  function automatic obs_t expect_at(input int r);
    obs_t e;
    int   k;
    e       = '0;
    e.busy  = (r >= 0) && (r <= 2*D);
    e.ready = (r >= 1) && (r <= D);
    e.done  = (r == 2*D + 1);
    e.und   = sticky;
    for (int i = 0; i < D; i++) begin
      if (r == 1 + i) e.ar[i] = 1'b1;
      k = r - 2 - i;
      if (k >= 0 && k < D && !minv[k]) begin
        e.a[i*W +: W] = ma[k][i];
        e.b[i*W +: W] = mb[k][i];
      end
    end
    e.br = e.ar;
    for (int kk = 0; kk < D; kk++)
      if (minv[kk] && r >= kk + 2) e.und = 1'b1;
    return e;
  endfunction

  function automatic obs_t idle_exp();
    obs_t e;
    e     = '0;
    e.und = sticky;
    return e;
  endfunction

  task automatic tick_push(input obs_t e);
    @(posedge i_clock);
    #1;
    exp_q.push_back(e);
    stamp_q.push_back(cyc);
  endtask

  task automatic drive_random();
    i_valid = 1'($urandom);
    i_a_col = D*W'($urandom);
    i_b_row = D*W'($urandom);
  endtask

  // mode 0: lane pattern 16*i+k, 1: negative operands, 2: random. rst_at<0 means no reset.
  task automatic run_op(input int id, input int mode, input int rst_at);
    int tp;
    for (int k = 0; k < D; k++)
      for (int i = 0; i < D; i++) begin
        case (mode)
          0:       begin ma[k][i] = W'(16*i + k); mb[k][i] = W'(8'hC0 + 16*i + k); end
          1:       begin ma[k][i] = 8'h80;        mb[k][i] = 8'h40; end
          default: begin ma[k][i] = W'($urandom); mb[k][i] = W'($urandom); end
        endcase
      end
    i_start = 1'b1;
    drive_random();
    tp = cyc + 1;
    for (int r = 0; r <= 2*D + 1; r++) begin
      tick_push(expect_at(r));
      i_start = 1'($urandom);
      drive_random();
      if (r >= 1 && r <= D) begin
        i_valid = !minv[r-1];
        if (i_valid)
          for (int i = 0; i < D; i++) begin
            i_a_col[i*W +: W] = ma[r-1][i];
            i_b_row[i*W +: W] = mb[r-1][i];
          end
      end
      if (r == rst_at) begin
        i_reset = 1'b1;
        sticky  = 1'b0;
        tick_push(idle_exp());
        i_reset = 1'b0;
        i_start = 1'b0;
        break;
      end
    end
    if (rst_at < 0) sticky = expect_at(2*D + 1).und;
    tick_push(idle_exp());
    i_start = 1'b0;
    $display("op %0d mode %0d tP=%0d reset_at=%0d inval=%b%b%b%b sticky=%0b",
             id, mode, tp, rst_at, minv[3], minv[2], minv[1], minv[0], sticky);
  endtask

  obs_t mon_act, mon_exp;
  int   mon_stamp;

  always @(negedge i_clock) begin
    if (exp_q.size() > 0) begin
      mon_exp   = exp_q.pop_front();
      mon_stamp = stamp_q.pop_front();
      mon_act.a     = o_a;
      mon_act.b     = o_b;
      mon_act.ar    = o_a_reset;
      mon_act.br    = o_b_reset;
      mon_act.busy  = o_busy;
      mon_act.ready = o_ready;
      mon_act.done  = o_done;
      mon_act.und   = o_underrun;
      n_cmp++;
      if (mon_stamp != cyc || mon_act !== mon_exp) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d stamp=%0d got a=%h b=%h ar=%b br=%b busy=%b rdy=%b done=%b und=%b required a=%h b=%h ar=%b br=%b busy=%b rdy=%b done=%b und=%b",
                 cyc, mon_stamp, mon_act.a, mon_act.b, mon_act.ar, mon_act.br, mon_act.busy,
                 mon_act.ready, mon_act.done, mon_act.und, mon_exp.a, mon_exp.b, mon_exp.ar,
                 mon_exp.br, mon_exp.busy, mon_exp.ready, mon_exp.done, mon_exp.und);
      end
    end
  end

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_a_col = '0;
    i_b_row = '0;
    for (int k = 0; k < D; k++) minv[k] = 1'b0;
    repeat (3) tick_push(idle_exp());
    i_reset = 1'b0;
    repeat (2) tick_push(idle_exp());

    run_op(0, 0, -1);
    run_op(1, 1, -1);
    minv[2] = 1'b1;
    run_op(2, 2, -1);
    minv[2] = 1'b0;
    run_op(3, 2, 5);
    run_op(4, 2, -1);
    for (int n = 5; n < 15; n++) begin
      for (int k = 0; k < D; k++) minv[k] = ($urandom_range(7) == 0);
      run_op(n, 2, (n == 10) ? int'($urandom_range(2*D)) : -1);
    end

    repeat (3) tick_push(idle_exp());
    @(posedge i_clock);
    @(posedge i_clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
